// File: rtl/eth_rx_crc_check.sv
// Ethernet receive checker: strips preamble/SFD, forwards payload minus FCS through
// a 4-byte delay line, and checks the CRC-32 residue and length at end of frame.
module eth_rx_crc_check #(
  parameter int MAX_BYTES = 1518,
  parameter int MIN_BYTES = 5,
  localparam int CW = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_dv,
  input  logic [7:0]    rx_data,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          frame_done,
  output logic          crc_ok,
  output logic          crc_err,
  output logic [CW-1:0] byte_count
);

  localparam logic [31:0]   POLY    = 32'hEDB88320;
  localparam logic [31:0]   RESIDUE = 32'hDEBB20E3;
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_BYTES);
  localparam logic [CW-1:0] SAT_C   = CW'(MAX_BYTES + 1);
  localparam logic [CW-1:0] MIN_C   = CW'(MIN_BYTES);
  localparam logic [CW-1:0] FCS_C   = CW'(4);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     crc_q, crc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0][7:0] dl_q, dl_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            frame_done_q, frame_done_d;
  logic            crc_ok_q, crc_ok_d;
  logic            crc_err_q, crc_err_d;
  logic [CW-1:0]   byte_count_q, byte_count_d;
  logic            good;

  // Reflected, LSB-first byte update; no final XOR so a clean frame leaves the magic residue.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    count_d      = count_q;
    dl_d         = dl_q;
    out_valid_d  = 1'b0;
    out_data_d   = 8'h00;
    frame_done_d = 1'b0;
    crc_ok_d     = 1'b0;
    crc_err_d    = 1'b0;
    byte_count_d = '0;
    good         = (crc_q == RESIDUE) && (count_q >= MIN_C) && (count_q <= MAX_C);

    unique case (state_q)
      // IDLE evaluates its first byte exactly as PRE would.
      IDLE, PRE: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end else if (rx_data == 8'h55) begin
          state_d = PRE;
        end else if (rx_data == 8'hD5) begin
          state_d = DATA;
          crc_d   = 32'hFFFFFFFF;
          count_d = '0;
          dl_d    = '0;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (rx_dv) begin
          crc_d   = crc_step(crc_q, rx_data);
          count_d = (count_q == SAT_C) ? count_q : count_q + CW'(1);
          dl_d    = {dl_q[2:0], rx_data};
          // The line is full once four bytes are in; the oldest pops on every push.
          if (count_q >= FCS_C) begin
            out_valid_d = 1'b1;
            out_data_d  = dl_q[3];
          end
        end else begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          crc_ok_d     = good;
          crc_err_d    = !good;
          byte_count_d = (count_q >= FCS_C) ? count_q - FCS_C : '0;
        end
      end
      DROP: begin
        if (!rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      crc_q        <= 32'hFFFFFFFF;
      count_q      <= '0;
      dl_q         <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      frame_done_q <= 1'b0;
      crc_ok_q     <= 1'b0;
      crc_err_q    <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      count_q      <= count_d;
      dl_q         <= dl_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      crc_ok_q     <= crc_ok_d;
      crc_err_q    <= crc_err_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
  assign crc_ok     = crc_ok_q;
  assign crc_err    = crc_err_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_eth_rx_crc_check.sv
// Directed bench for eth_rx_crc_check: "123456789" frames with known FCS, corrupt,
// bad preamble, runt, reset mid-frame, back-to-back and oversize frames.
module tb_eth_rx_crc_check;
  localparam int CW = $clog2(1518 + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          frame_done;
  logic          crc_ok;
  logic          crc_err;
  logic [CW-1:0] byte_count;

  eth_rx_crc_check dut (
    .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_data(rx_data),
    .out_valid(out_valid), .out_data(out_data), .frame_done(frame_done),
    .crc_ok(crc_ok), .crc_err(crc_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] stim[$];
  logic [7:0] rxq[$];
  int         fd_cnt;
  int         ok_cnt;
  logic       last_ok, last_err;
  logic [31:0] last_bc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) rxq.push_back(out_data);
      if (frame_done) begin
        fd_cnt++;
        if (crc_ok) ok_cnt++;
        last_ok  = crc_ok;
        last_err = crc_err;
        last_bc  = 32'(byte_count);
      end
    end
  end

  task automatic clear_obs();
    rxq.delete();
    fd_cnt = 0;
    ok_cnt = 0;
    last_ok = 1'b0;
    last_err = 1'b0;
    last_bc = '0;
  endtask

  task automatic build_t2(input logic [7:0] b4);
    stim.delete();
    repeat (7) stim.push_back(8'h55);
    stim.push_back(8'hD5);
    for (int i = 0; i < 9; i++) stim.push_back(i == 4 ? b4 : 8'(8'h31 + i));
    stim.push_back(8'h26); stim.push_back(8'h39);
    stim.push_back(8'hF4); stim.push_back(8'hCB);
  endtask

  // gap = number of rx_dv-low cycles before returning (1 gives back-to-back)
  task automatic play(input int gap);
    foreach (stim[i]) begin
      @(posedge clk); #1;
      rx_dv = 1'b1;
      rx_data = stim[i];
    end
    @(posedge clk); #1;
    rx_dv = 1'b0;
    rx_data = 8'h00;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic check_good(input string tag, input int nbytes);
    chk({tag, "_nout"}, rxq.size(), 9 * nbytes);
    for (int i = 0; i < rxq.size() && i < 9; i++)
      chk({tag, "_byte"}, rxq[i], 32'(8'h31 + i));
    chk({tag, "_fd"}, fd_cnt, nbytes);
    chk({tag, "_okcnt"}, ok_cnt, nbytes);
    chk({tag, "_err"}, last_err, 0);
    chk({tag, "_bc"}, last_bc, 9);
  endtask

  initial begin
    clear_obs();
    // T1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_crc_ok", crc_ok, 0);
    chk("rst_crc_err", crc_err, 0);
    chk("rst_byte_count", 32'(byte_count), 0);
    chk("rst_crc_reg", dut.crc_q, 32'hFFFFFFFF);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    chk("idle_fd", fd_cnt, 0);

    // T2: good frame
    clear_obs(); build_t2(8'h35); play(4);
    check_good("t2", 1);

    // T3: corrupt payload byte
    clear_obs(); build_t2(8'h34); play(4);
    chk("t3_nout", rxq.size(), 9);
    if (rxq.size() > 4) chk("t3_byte4", rxq[4], 8'h34);
    chk("t3_fd", fd_cnt, 1);
    chk("t3_ok", last_ok, 0);
    chk("t3_err", last_err, 1);
    chk("t3_bc", last_bc, 9);

    // T4: bad preamble dropped, then clean frame accepted
    clear_obs();
    stim.delete();
    stim.push_back(8'h55); stim.push_back(8'h55);
    stim.push_back(8'hAA); stim.push_back(8'hD5);
    for (int i = 0; i < 9; i++) stim.push_back(8'(8'h31 + i));
    stim.push_back(8'h26); stim.push_back(8'h39);
    stim.push_back(8'hF4); stim.push_back(8'hCB);
    play(4);
    chk("t4_nout", rxq.size(), 0);
    chk("t4_fd", fd_cnt, 0);
    clear_obs(); build_t2(8'h35); play(4);
    check_good("t4b", 1);

    // T5: runt
    clear_obs();
    stim.delete();
    stim.push_back(8'h55); stim.push_back(8'hD5);
    stim.push_back(8'hAB); stim.push_back(8'hCD); stim.push_back(8'hEF);
    play(4);
    chk("t5_nout", rxq.size(), 0);
    chk("t5_fd", fd_cnt, 1);
    chk("t5_ok", last_ok, 0);
    chk("t5_err", last_err, 1);
    chk("t5_bc", last_bc, 0);

    // T6: reset during 4th payload byte
    clear_obs(); build_t2(8'h35);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      rx_dv = 1'b1;
      rx_data = stim[i];
    end
    @(posedge clk); #1;
    rx_data = stim[11];
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_frame_done", frame_done, 0);
    reset = 1'b0;
    rx_dv = 1'b0;
    rx_data = 8'h00;
    repeat (4) @(posedge clk);
    chk("t6_nout", rxq.size(), 0);
    chk("t6_fd", fd_cnt, 0);
    clear_obs(); build_t2(8'h35); play(4);
    check_good("t6b", 1);

    // Back-to-back: one low cycle between two good frames
    clear_obs(); build_t2(8'h35);
    play(1);
    play(4);
    chk("b2b_nout", rxq.size(), 18);
    if (rxq.size() == 18) chk("b2b_byte9", rxq[9], 8'h31);
    chk("b2b_fd", fd_cnt, 2);
    chk("b2b_okcnt", ok_cnt, 2);

    // Oversize: 1520 bytes after SFD, counter saturates at 1519
    clear_obs();
    stim.delete();
    stim.push_back(8'h55); stim.push_back(8'hD5);
    repeat (1520) stim.push_back(8'h00);
    play(4);
    chk("ovs_nout", rxq.size(), 1516);
    chk("ovs_fd", fd_cnt, 1);
    chk("ovs_ok", last_ok, 0);
    chk("ovs_err", last_err, 1);
    chk("ovs_bc", last_bc, 1515);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
